// File: rtl/quad_pixel_writer_if.sv
// Quad input bus (drawer -> writer) and single-pixel write bus (writer -> framebuffer).
// Both use rts/rtr handshakes: a transfer happens on a cycle where rts and rtr are both high.
interface qpw_quad_if;
    logic        in_rts;
    logic        in_rtr;
    logic [9:0]  draw_x_0;
    logic [9:0]  draw_x_1;
    logic [9:0]  draw_x_2;
    logic [9:0]  draw_x_3;
    logic [9:0]  draw_y_0;
    logic [9:0]  draw_y_1;
    logic [9:0]  draw_y_2;
    logic [9:0]  draw_y_3;
    logic [11:0] color;

    modport master (
        output in_rts, draw_x_0, draw_x_1, draw_x_2, draw_x_3,
               draw_y_0, draw_y_1, draw_y_2, draw_y_3, color,
        input  in_rtr
    );
    modport slave (
        input  in_rts, draw_x_0, draw_x_1, draw_x_2, draw_x_3,
               draw_y_0, draw_y_1, draw_y_2, draw_y_3, color,
        output in_rtr
    );
endinterface

interface qpw_pix_if #(parameter int ADDR_W = 19);
    logic              out_rts;
    logic              out_rtr;
    logic [ADDR_W-1:0] out_addr;
    logic [11:0]       out_color;

    modport master (output out_rts, out_addr, out_color, input out_rtr);
    modport slave  (input out_rts, out_addr, out_color, output out_rtr);
endinterface

// File: rtl/quad_pixel_writer.sv
// Serializes a 4-point quad into pixel writes, dropping off-screen points and in-quad duplicates.
// Latency: first write valid 2 cycles after accept; a stalled write holds address/color and the FSM.
module quad_pixel_writer #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int ADDR_W   = 19
) (
    input  logic            clk,
    input  logic            rst,
    qpw_quad_if.slave       quad,
    qpw_pix_if.master       pix,
    output logic [15:0]     clip_cnt
);
    typedef enum logic [1:0] {IDLE, SCAN, SEND} state_t;

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0][9:0]   x_q, x_d;
    logic [3:0][9:0]   y_q, y_d;
    logic [11:0]       color_q, color_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [11:0]       out_color_q, out_color_d;
    logic [15:0]       clip_cnt_q, clip_cnt_d;

    logic [9:0]        cur_x;
    logic [9:0]        cur_y;
    logic              in_range;
    logic              dup;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        x_d         = x_q;
        y_d         = y_q;
        color_d     = color_q;
        out_addr_d  = out_addr_q;
        out_color_d = out_color_q;
        clip_cnt_d  = clip_cnt_q;

        cur_x    = x_q[idx_q];
        cur_y    = y_q[idx_q];
        in_range = (32'(cur_x) < SCREEN_W) && (32'(cur_y) < SCREEN_H);
        // Only earlier points of the quad count, so the first copy is the one emitted.
        dup = 1'b0;
        for (int j = 0; j < 3; j++) begin
            if ((2'(j) < idx_q) && (x_q[j] == cur_x) && (y_q[j] == cur_y)) begin
                dup = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (quad.in_rts) begin
                    x_d     = {quad.draw_x_3, quad.draw_x_2, quad.draw_x_1, quad.draw_x_0};
                    y_d     = {quad.draw_y_3, quad.draw_y_2, quad.draw_y_1, quad.draw_y_0};
                    color_d = quad.color;
                    idx_d   = 2'd0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (!in_range && (clip_cnt_q != 16'hFFFF)) begin
                    clip_cnt_d = clip_cnt_q + 16'd1;
                end
                if (in_range && !dup) begin
                    out_addr_d  = ADDR_W'(cur_y) * ADDR_W'(SCREEN_W) + ADDR_W'(cur_x);
                    out_color_d = color_q;
                    state_d     = SEND;
                end else if (idx_q == 2'd3) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            SEND: begin
                if (pix.out_rtr) begin
                    if (idx_q == 2'd3) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = SCAN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            x_q         <= '0;
            y_q         <= '0;
            color_q     <= '0;
            out_addr_q  <= '0;
            out_color_q <= '0;
            clip_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            x_q         <= x_d;
            y_q         <= y_d;
            color_q     <= color_d;
            out_addr_q  <= out_addr_d;
            out_color_q <= out_color_d;
            clip_cnt_q  <= clip_cnt_d;
        end
    end

    assign quad.in_rtr   = (state_q == IDLE);
    assign pix.out_rts   = (state_q == SEND);
    assign pix.out_addr  = out_addr_q;
    assign pix.out_color = out_color_q;
    assign clip_cnt      = clip_cnt_q;
endmodule

// File: tb/tb_quad_pixel_writer.sv
// Directed and randomized quads checked against a point-list model of the writer.
module tb_quad_pixel_writer;
    typedef logic [3:0][9:0] quad_t;

    logic        clk;
    logic        rst;
    logic [15:0] clip_cnt;
    int          checks;
    int          errors;
    int          exp_clip;

    qpw_quad_if                q_if ();
    qpw_pix_if #(.ADDR_W(19))  p_if ();

    quad_pixel_writer #(.SCREEN_W(640), .SCREEN_H(480), .ADDR_W(19)) dut (
        .clk      (clk),
        .rst      (rst),
        .quad     (q_if),
        .pix      (p_if),
        .clip_cnt (clip_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic quad_t mk4(input int a, input int b, input int c, input int d);
        quad_t q;
        q[0] = 10'(a);
        q[1] = 10'(b);
        q[2] = 10'(c);
        q[3] = 10'(d);
        return q;
    endfunction

    task automatic drive_quad(input quad_t xs, input quad_t ys, input logic [11:0] col);
        q_if.draw_x_0 = xs[0]; q_if.draw_x_1 = xs[1];
        q_if.draw_x_2 = xs[2]; q_if.draw_x_3 = xs[3];
        q_if.draw_y_0 = ys[0]; q_if.draw_y_1 = ys[1];
        q_if.draw_y_2 = ys[2]; q_if.draw_y_3 = ys[3];
        q_if.color    = col;
    endtask

    // Starts and ends on a falling edge with the DUT idle.
    // mode 0: out_rtr always 1; mode 1: first write held 10 cycles; mode 2: random out_rtr.
    task automatic run_quad(input quad_t xs, input quad_t ys, input logic [11:0] col,
                            input int mode, input string tag);
        int  exp_addr[$];
        int  nw;
        int  stalls;
        int  held;
        int  done_k;
        int  first_rts;
        bit  seen;
        for (int i = 0; i < 4; i++) begin
            seen = 1'b0;
            for (int j = 0; j < i; j++) begin
                if (xs[j] == xs[i] && ys[j] == ys[i]) seen = 1'b1;
            end
            if (int'(xs[i]) >= 640 || int'(ys[i]) >= 480) begin
                if (exp_clip < 65535) exp_clip++;
            end else if (!seen) begin
                exp_addr.push_back(int'(ys[i]) * 640 + int'(xs[i]));
            end
        end

        check({tag, ":in_rtr_idle"}, 32'(q_if.in_rtr), 1);
        drive_quad(xs, ys, col);
        q_if.in_rts = 1'b1;
        @(posedge clk);
        #1;
        q_if.in_rts = 1'b0;
        drive_quad(quad_t'({$urandom, $urandom}), quad_t'({$urandom, $urandom}), 12'($urandom));

        nw = 0; stalls = 0; held = 0; done_k = 0; first_rts = -1;
        for (int k = 1; k <= 80 && done_k == 0; k++) begin
            @(negedge clk);
            if (q_if.in_rtr) begin
                done_k = k;
            end else if (p_if.out_rts) begin
                if (first_rts < 0) first_rts = k;
                case (mode)
                    0:       p_if.out_rtr = 1'b1;
                    1:       p_if.out_rtr = (nw > 0) || (held >= 10);
                    default: p_if.out_rtr = 1'($urandom_range(0, 1));
                endcase
                if (nw < exp_addr.size()) begin
                    check({tag, ":addr"}, 32'(p_if.out_addr), exp_addr[nw]);
                    check({tag, ":color"}, 32'(p_if.out_color), 32'(col));
                end else begin
                    check({tag, ":extra_write"}, nw + 1, exp_addr.size());
                end
                if (p_if.out_rtr) nw++;
                else begin
                    stalls++;
                    held++;
                end
            end else begin
                p_if.out_rtr = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        if (done_k == 0) check({tag, ":timeout"}, 0, 1);
        else check({tag, ":done_cycle"}, done_k, 5 + exp_addr.size() + stalls);
        check({tag, ":writes"}, nw, exp_addr.size());
        check({tag, ":clip_cnt"}, 32'(clip_cnt), exp_clip);
        if (int'(xs[0]) < 640 && int'(ys[0]) < 480) begin
            check({tag, ":first_rts"}, first_rts, 2);
        end
    endtask

    function automatic int rand_coord(input int lim);
        case ($urandom_range(0, 5))
            0, 1, 2: return int'($urandom_range(0, lim - 1));
            3:       return lim - 1;
            4:       return lim;
            default: return 1019;
        endcase
    endfunction

    initial begin : main
        quad_t xs;
        quad_t ys;
        int    nw;
        int    j;
        checks = 0; errors = 0; exp_clip = 0;
        rst = 1'b1;
        q_if.in_rts = 1'b0;
        p_if.out_rtr = 1'b0;
        drive_quad('0, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset:in_rtr", 32'(q_if.in_rtr), 1);
        check("reset:out_rts", 32'(p_if.out_rts), 0);
        check("reset:out_addr", 32'(p_if.out_addr), 0);
        check("reset:out_color", 32'(p_if.out_color), 0);
        check("reset:clip_cnt", 32'(clip_cnt), 0);
        rst = 1'b0;
        @(negedge clk);

        run_quad(mk4(110, 110, 90, 90), mk4(60, 40, 60, 40), 12'hF0A, 0, "distinct");
        run_quad(mk4(110, 110, 90, 90), mk4(50, 50, 50, 50), 12'h123, 0, "dups");
        run_quad(mk4(639, 640, 639, 1023), mk4(479, 479, 480, 0), 12'h7E1, 0, "clip");
        run_quad(mk4(700, 700, 700, 700), mk4(500, 500, 500, 500), 12'h0FF, 0, "alloff");
        run_quad(mk4(110, 110, 90, 90), mk4(60, 40, 60, 40), 12'hF0A, 1, "backpressure");

        for (int q = 0; q < 10; q++) begin
            for (int i = 0; i < 4; i++) begin
                if (i > 0 && $urandom_range(0, 3) == 0) begin
                    j = int'($urandom_range(0, i - 1));
                    xs[i] = xs[j];
                    ys[i] = ys[j];
                end else begin
                    xs[i] = 10'(rand_coord(640));
                    ys[i] = 10'(rand_coord(480));
                end
            end
            run_quad(xs, ys, 12'($urandom), 2, "random");
        end

        // Reset while the second pixel of a quad is pending.
        drive_quad(mk4(110, 110, 90, 90), mk4(60, 40, 60, 40), 12'hF0A);
        q_if.in_rts = 1'b1;
        p_if.out_rtr = 1'b1;
        @(posedge clk);
        #1;
        q_if.in_rts = 1'b0;
        nw = 0;
        for (int k = 0; k < 20 && !rst; k++) begin
            @(negedge clk);
            if (p_if.out_rts) begin
                if (nw == 1) begin
                    p_if.out_rtr = 1'b0;
                    rst = 1'b1;
                end else begin
                    nw++;
                end
            end
        end
        check("rst_mid:asserted", 32'(rst), 1);
        @(negedge clk);
        check("rst_mid:out_rts", 32'(p_if.out_rts), 0);
        check("rst_mid:in_rtr", 32'(q_if.in_rtr), 1);
        check("rst_mid:out_addr", 32'(p_if.out_addr), 0);
        check("rst_mid:clip_cnt", 32'(clip_cnt), 0);
        rst = 1'b0;
        exp_clip = 0;
        @(negedge clk);
        check("rst_mid:no_pixel", 32'(p_if.out_rts), 0);
        run_quad(mk4(110, 110, 90, 90), mk4(60, 40, 60, 40), 12'hF0A, 0, "after_rst");

        // 16384 all-clipped quads back to back: 65536 clips must stop at 0xFFFF.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_clip = 0;
        drive_quad(mk4(700, 700, 700, 700), mk4(500, 500, 500, 500), 12'h000);
        q_if.in_rts = 1'b1;
        p_if.out_rtr = 1'b1;
        repeat (16384 * 5) @(posedge clk);
        @(negedge clk);
        q_if.in_rts = 1'b0;
        exp_clip = 65535;
        check("saturate:clip_cnt", 32'(clip_cnt), 32'hFFFF);
        run_quad(mk4(700, 1019, 0, 5), mk4(500, 3, 1019, 479), 12'hABC, 0, "saturate_more");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
